// File: rtl/rvfi_channel_buffer.sv
// rvfi_channel_buffer
//
// Serializes up to NRET RVFI retirements per cycle into a single-channel
// valid/ready stream. Valid channels of one cycle are compacted (ascending
// channel index, gaps removed) into a DEPTH-entry FIFO and replayed one per
// cycle. A burst that does not fit is dropped whole and flags `overflow`;
// popped `order` values that are not consecutive flag `order_err`.
//
// Ports:
//   clock, reset                : rising-edge clock, async active-high reset
//   rvfi_*                      : packed NRET-channel RVFI bus, channel c of a
//                                 W-bit field at [c*W +: W]
//   out_valid / out_ready       : single-channel handshake for the head entry
//   out_*                       : head entry fields (all zero when !out_valid)
//   level                       : current FIFO occupancy
//   overflow                    : sticky, a burst was dropped
//   order_err                   : sticky, popped order was not previous+1
module rvfi_channel_buffer #(
    parameter int NRET  = 1,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NRET-1:0]            rvfi_valid,
    input  logic [NRET-1:0]            rvfi_trap,
    input  logic [NRET-1:0]            rvfi_halt,
    input  logic [NRET-1:0]            rvfi_intr,
    input  logic [64*NRET-1:0]         rvfi_order,
    input  logic [ILEN*NRET-1:0]       rvfi_insn,
    input  logic [2*NRET-1:0]          rvfi_mode,
    input  logic [2*NRET-1:0]          rvfi_ixl,
    input  logic [5*NRET-1:0]          rvfi_rs1_addr,
    input  logic [5*NRET-1:0]          rvfi_rs2_addr,
    input  logic [5*NRET-1:0]          rvfi_rd_addr,
    input  logic [XLEN*NRET-1:0]       rvfi_rs1_rdata,
    input  logic [XLEN*NRET-1:0]       rvfi_rs2_rdata,
    input  logic [XLEN*NRET-1:0]       rvfi_rd_wdata,
    input  logic [XLEN*NRET-1:0]       rvfi_pc_rdata,
    input  logic [XLEN*NRET-1:0]       rvfi_pc_wdata,
    input  logic [XLEN*NRET-1:0]       rvfi_mem_addr,
    input  logic [XLEN*NRET-1:0]       rvfi_mem_rdata,
    input  logic [XLEN*NRET-1:0]       rvfi_mem_wdata,
    input  logic [(XLEN/8)*NRET-1:0]   rvfi_mem_rmask,
    input  logic [(XLEN/8)*NRET-1:0]   rvfi_mem_wmask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_trap,
    output logic                       out_halt,
    output logic                       out_intr,
    output logic [63:0]                out_order,
    output logic [ILEN-1:0]            out_insn,
    output logic [1:0]                 out_mode,
    output logic [1:0]                 out_ixl,
    output logic [4:0]                 out_rs1_addr,
    output logic [4:0]                 out_rs2_addr,
    output logic [4:0]                 out_rd_addr,
    output logic [XLEN-1:0]            out_rs1_rdata,
    output logic [XLEN-1:0]            out_rs2_rdata,
    output logic [XLEN-1:0]            out_rd_wdata,
    output logic [XLEN-1:0]            out_pc_rdata,
    output logic [XLEN-1:0]            out_pc_wdata,
    output logic [XLEN-1:0]            out_mem_addr,
    output logic [XLEN-1:0]            out_mem_rdata,
    output logic [XLEN-1:0]            out_mem_wdata,
    output logic [XLEN/8-1:0]          out_mem_rmask,
    output logic [XLEN/8-1:0]          out_mem_wmask,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       order_err
);

    localparam int MW = XLEN / 8;
    // A 1-entry FIFO still needs a 1-bit pointer; wrapping modulo 2 instead
    // of 1 is harmless because occupancy, not pointers, decides full/empty.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int EW = 3 + 64 + ILEN + 4 + 15 + 8 * XLEN + 2 * MW;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [EW-1:0] mem [0:(1<<AW)-1];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [63:0]   last_order;
    logic          order_seen;

    logic [EW-1:0] in_entry [NRET];
    logic [AW-1:0] slot     [NRET];
    logic [LW-1:0] k;
    logic [LW-1:0] free;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Each valid channel lands at wptr + (number of valid channels below it),
    // which compacts the burst without gaps.
    // NOTE: every variable assigned here gets a value before any condition,
    // so the block stays purely combinational and no latch is inferred.
    always_comb begin
        k = '0;
        for (int c = 0; c < NRET; c++) begin
            in_entry[c] = {rvfi_trap[c], rvfi_halt[c], rvfi_intr[c],
                           rvfi_order[c*64 +: 64], rvfi_insn[c*ILEN +: ILEN],
                           rvfi_mode[c*2 +: 2], rvfi_ixl[c*2 +: 2],
                           rvfi_rs1_addr[c*5 +: 5], rvfi_rs2_addr[c*5 +: 5],
                           rvfi_rd_addr[c*5 +: 5],
                           rvfi_rs1_rdata[c*XLEN +: XLEN], rvfi_rs2_rdata[c*XLEN +: XLEN],
                           rvfi_rd_wdata[c*XLEN +: XLEN], rvfi_pc_rdata[c*XLEN +: XLEN],
                           rvfi_pc_wdata[c*XLEN +: XLEN], rvfi_mem_addr[c*XLEN +: XLEN],
                           rvfi_mem_rdata[c*XLEN +: XLEN], rvfi_mem_wdata[c*XLEN +: XLEN],
                           rvfi_mem_rmask[c*MW +: MW], rvfi_mem_wmask[c*MW +: MW]};
            slot[c] = wptr + AW'(k);
            if (rvfi_valid[c]) begin
                k = k + LW'(1);
            end
        end
    end

    // Space test uses the occupancy before this cycle's pop, so a pop never
    // makes room for a same-cycle burst.
    assign free      = DEPTH_L - level;
    assign push      = (k != '0) && (k <= free);
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;

    // NOTE: storage is deliberately left out of reset; stale contents are
    // unreachable because occupancy is cleared and the outputs are masked.
    always_ff @(posedge clock) begin
        if (push) begin
            for (int c = 0; c < NRET; c++) begin
                if (rvfi_valid[c]) begin
                    mem[slot[c]] <= in_entry[c];
                end
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            order_err  <= 1'b0;
            last_order <= '0;
            order_seen <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(k);
            end else if (k != '0) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rptr       <= rptr + AW'(1);
                last_order <= out_order;
                order_seen <= 1'b1;
                if (order_seen && (out_order != last_order + 64'd1)) begin
                    order_err <= 1'b1;
                end
            end
            level <= level + (push ? k : '0) - LW'(pop);
        end
    end

    assign head = out_valid ? mem[rptr] : '0;

    assign {out_trap, out_halt, out_intr, out_order, out_insn, out_mode, out_ixl,
            out_rs1_addr, out_rs2_addr, out_rd_addr,
            out_rs1_rdata, out_rs2_rdata, out_rd_wdata, out_pc_rdata, out_pc_wdata,
            out_mem_addr, out_mem_rdata, out_mem_wdata,
            out_mem_rmask, out_mem_wmask} = head;

endmodule

// File: tb/tb_rvfi_channel_buffer.sv
// Self-checking bench for rvfi_channel_buffer (NRET=4, DEPTH=4).
// Stimulus side keeps a queue-based reference FIFO and pushes every accepted
// retirement into a scoreboard; a negedge monitor compares the DUT head and
// status against it and pops on each handshake.
module tb_rvfi_channel_buffer;

    localparam int NRET  = 4;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam int MW    = XLEN / 8;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int EW    = 3 + 64 + ILEN + 4 + 15 + 8 * XLEN + 2 * MW;

    logic clock;
    logic reset;
    logic [NRET-1:0]          rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [64*NRET-1:0]       rvfi_order;
    logic [ILEN*NRET-1:0]     rvfi_insn;
    logic [2*NRET-1:0]        rvfi_mode, rvfi_ixl;
    logic [5*NRET-1:0]        rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [XLEN*NRET-1:0]     rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [XLEN*NRET-1:0]     rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
    logic [XLEN*NRET-1:0]     rvfi_mem_rdata, rvfi_mem_wdata;
    logic [MW*NRET-1:0]       rvfi_mem_rmask, rvfi_mem_wmask;

    logic                     out_valid, out_ready;
    logic                     out_trap, out_halt, out_intr;
    logic [63:0]              out_order;
    logic [ILEN-1:0]          out_insn;
    logic [1:0]               out_mode, out_ixl;
    logic [4:0]               out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [XLEN-1:0]          out_rs1_rdata, out_rs2_rdata, out_rd_wdata;
    logic [XLEN-1:0]          out_pc_rdata, out_pc_wdata, out_mem_addr;
    logic [XLEN-1:0]          out_mem_rdata, out_mem_wdata;
    logic [MW-1:0]            out_mem_rmask, out_mem_wmask;
    logic [LW-1:0]            level;
    logic                     overflow, order_err;

    rvfi_channel_buffer #(.NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
        .rvfi_intr(rvfi_intr), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_trap(out_trap), .out_halt(out_halt), .out_intr(out_intr),
        .out_order(out_order), .out_insn(out_insn), .out_mode(out_mode),
        .out_ixl(out_ixl), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
        .out_rd_addr(out_rd_addr), .out_rs1_rdata(out_rs1_rdata),
        .out_rs2_rdata(out_rs2_rdata), .out_rd_wdata(out_rd_wdata),
        .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
        .out_mem_addr(out_mem_addr), .out_mem_rdata(out_mem_rdata),
        .out_mem_wdata(out_mem_wdata), .out_mem_rmask(out_mem_rmask),
        .out_mem_wmask(out_mem_wmask),
        .level(level), .overflow(overflow), .order_err(order_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO of orders plus sticky flags.
    logic [63:0]   mq[$];
    logic [EW-1:0] exp_q[$];
    logic          m_ovf, m_oerr, m_seen;
    logic [63:0]   m_last;
    // Expected DUT state during the current cycle.
    int            exp_level_now;
    logic          exp_ovf_now, exp_oerr_now;
    logic          started;
    logic [63:0]   next_ord;
    logic [EW-1:0] head;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] pack_ch(input int c);
        return {rvfi_trap[c], rvfi_halt[c], rvfi_intr[c],
                rvfi_order[c*64 +: 64], rvfi_insn[c*ILEN +: ILEN],
                rvfi_mode[c*2 +: 2], rvfi_ixl[c*2 +: 2],
                rvfi_rs1_addr[c*5 +: 5], rvfi_rs2_addr[c*5 +: 5], rvfi_rd_addr[c*5 +: 5],
                rvfi_rs1_rdata[c*XLEN +: XLEN], rvfi_rs2_rdata[c*XLEN +: XLEN],
                rvfi_rd_wdata[c*XLEN +: XLEN], rvfi_pc_rdata[c*XLEN +: XLEN],
                rvfi_pc_wdata[c*XLEN +: XLEN], rvfi_mem_addr[c*XLEN +: XLEN],
                rvfi_mem_rdata[c*XLEN +: XLEN], rvfi_mem_wdata[c*XLEN +: XLEN],
                rvfi_mem_rmask[c*MW +: MW], rvfi_mem_wmask[c*MW +: MW]};
    endfunction

    function automatic logic [64*NRET-1:0] mk_ord(input logic [63:0] o0, input logic [63:0] o1,
                                                  input logic [63:0] o2, input logic [63:0] o3);
        return {o3, o2, o1, o0};
    endfunction

    task automatic rand_fields();
        rvfi_trap = NRET'($urandom);
        rvfi_halt = NRET'($urandom);
        rvfi_intr = NRET'($urandom);
        for (int c = 0; c < NRET; c++) begin
            rvfi_insn[c*ILEN +: ILEN]      = $urandom;
            rvfi_mode[c*2 +: 2]            = 2'($urandom);
            rvfi_ixl[c*2 +: 2]             = 2'($urandom);
            rvfi_rs1_addr[c*5 +: 5]        = 5'($urandom);
            rvfi_rs2_addr[c*5 +: 5]        = 5'($urandom);
            rvfi_rd_addr[c*5 +: 5]         = 5'($urandom);
            rvfi_rs1_rdata[c*XLEN +: XLEN] = $urandom;
            rvfi_rs2_rdata[c*XLEN +: XLEN] = $urandom;
            rvfi_rd_wdata[c*XLEN +: XLEN]  = $urandom;
            rvfi_pc_rdata[c*XLEN +: XLEN]  = $urandom;
            rvfi_pc_wdata[c*XLEN +: XLEN]  = $urandom;
            rvfi_mem_addr[c*XLEN +: XLEN]  = $urandom;
            rvfi_mem_rdata[c*XLEN +: XLEN] = $urandom;
            rvfi_mem_wdata[c*XLEN +: XLEN] = $urandom;
            rvfi_mem_rmask[c*MW +: MW]     = MW'($urandom);
            rvfi_mem_wmask[c*MW +: MW]     = MW'($urandom);
        end
    endtask

    // Drive one cycle of stimulus (sampled at the next rising edge) and
    // advance the reference model across that edge.
    task automatic drive(input logic [NRET-1:0] v, input logic rdy, input logic [64*NRET-1:0] ords);
        int pre;
        int k;
        logic [63:0] o;
        @(posedge clock);
        #1;
        rand_fields();
        rvfi_valid = v;
        rvfi_order = ords;
        out_ready  = rdy;
        exp_level_now = mq.size();
        exp_ovf_now   = m_ovf;
        exp_oerr_now  = m_oerr;
        started       = 1'b1;
        pre = mq.size();
        if (pre != 0 && rdy) begin
            o = mq.pop_front();
            if (m_seen && o != m_last + 64'd1) m_oerr = 1'b1;
            m_last = o;
            m_seen = 1'b1;
        end
        k = $countones(v);
        if (k > DEPTH - pre) begin
            m_ovf = 1'b1;
        end else begin
            for (int c = 0; c < NRET; c++) begin
                if (v[c]) begin
                    mq.push_back(ords[c*64 +: 64]);
                    exp_q.push_back(pack_ch(c));
                end
            end
        end
    endtask

    task automatic idle(input logic rdy);
        drive('0, rdy, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++) idle(1'b1);
        idle(1'b1);
        idle(1'b1);
    endtask

    // Random cycle: valid channels take consecutive orders, with rare gaps.
    task automatic rand_step(input logic [NRET-1:0] v, input logic rdy);
        logic [64*NRET-1:0] ords;
        ords = '0;
        for (int c = 0; c < NRET; c++) begin
            ords[c*64 +: 64] = 64'($urandom);
            if (v[c]) begin
                if ($urandom_range(0, 31) == 0) next_ord = next_ord + 64'd1;
                ords[c*64 +: 64] = next_ord;
                next_ord = next_ord + 64'd1;
            end
        end
        drive(v, rdy, ords);
    endtask

    // Asynchronous reset in the middle of a cycle; status must clear at once.
    task automatic do_reset();
        @(posedge clock);
        #1;
        rvfi_valid = '0;
        out_ready  = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_level", 512'(level), 512'(0));
        check("rst_overflow", 512'(overflow), 512'(0));
        check("rst_order_err", 512'(order_err), 512'(0));
        check("rst_out_order", 512'(out_order), 512'(0));
        mq.delete();
        exp_q.delete();
        m_ovf = 1'b0; m_oerr = 1'b0; m_seen = 1'b0; m_last = '0;
        exp_level_now = 0; exp_ovf_now = 1'b0; exp_oerr_now = 1'b0;
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (started && !reset) begin
            head = {out_trap, out_halt, out_intr, out_order, out_insn, out_mode, out_ixl,
                    out_rs1_addr, out_rs2_addr, out_rd_addr,
                    out_rs1_rdata, out_rs2_rdata, out_rd_wdata, out_pc_rdata, out_pc_wdata,
                    out_mem_addr, out_mem_rdata, out_mem_wdata, out_mem_rmask, out_mem_wmask};
            check("out_valid", 512'(out_valid), 512'(exp_level_now != 0));
            check("level", 512'(level), 512'(exp_level_now));
            check("overflow", 512'(overflow), 512'(exp_ovf_now));
            check("order_err", 512'(order_err), 512'(exp_oerr_now));
            if (out_valid) begin
                check("head", 512'(head), 512'(exp_q.size() != 0 ? exp_q[0] : '0));
                if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end else begin
                check("idle_zero", 512'(head), 512'(0));
            end
        end
    end

    initial begin
        reset = 1'b1;
        started = 1'b0;
        out_ready = 1'b0;
        rvfi_valid = '0; rvfi_order = '0;
        rand_fields();
        m_ovf = 1'b0; m_oerr = 1'b0; m_seen = 1'b0; m_last = '0;
        exp_level_now = 0; exp_ovf_now = 1'b0; exp_oerr_now = 1'b0;
        next_ord = 64'd1000;
        repeat (2) @(posedge clock);
        #2;
        check("init_out_valid", 512'(out_valid), 512'(0));
        check("init_level", 512'(level), 512'(0));
        check("init_flags", 512'({overflow, order_err}), 512'(0));
        reset = 1'b0;

        // Two-channel burst, orders 10/11, drained back to back.
        drive(4'b0011, 1'b1, mk_ord(64'd10, 64'd11, 64'd0, 64'd0));
        drain();

        // Sparse burst: channels 1 and 3 compacted, channel 1 first.
        do_reset();
        drive(4'b1010, 1'b1, mk_ord(64'd0, 64'd5, 64'd0, 64'd6));
        drain();

        // Overflow with consumer stalled, then full FIFO rejecting a push
        // even while popping.
        do_reset();
        drive(4'b0111, 1'b0, mk_ord(64'd1, 64'd2, 64'd3, 64'd0));
        drive(4'b0011, 1'b0, mk_ord(64'd4, 64'd5, 64'd0, 64'd0));
        drive(4'b0001, 1'b0, mk_ord(64'd4, 64'd0, 64'd0, 64'd0));
        drive(4'b0001, 1'b1, mk_ord(64'd5, 64'd0, 64'd0, 64'd0));
        drive(4'b0000, 1'b0, '0);
        drain();

        // Order gap 7, 8, 10; then queue entries and overflow before reset.
        do_reset();
        drive(4'b0001, 1'b1, mk_ord(64'd7, 64'd0, 64'd0, 64'd0));
        drive(4'b0001, 1'b1, mk_ord(64'd8, 64'd0, 64'd0, 64'd0));
        drive(4'b0001, 1'b1, mk_ord(64'd10, 64'd0, 64'd0, 64'd0));
        drain();
        drive(4'b0111, 1'b0, mk_ord(64'd11, 64'd12, 64'd13, 64'd0));
        drive(4'b1111, 1'b0, mk_ord(64'd14, 64'd15, 64'd16, 64'd17));
        do_reset();

        // First post-reset pop is unchecked; 64-bit order wrap is legal.
        drive(4'b0001, 1'b1, mk_ord(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0));
        drive(4'b0001, 1'b1, mk_ord(64'd0, 64'd0, 64'd0, 64'd0));
        drain();

        // Random, sustainable rate: at most one retire on a random channel.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [NRET-1:0] v;
            v = '0;
            if ($urandom_range(0, 1) == 1) v[$urandom_range(0, NRET-1)] = 1'b1;
            rand_step(v, $urandom_range(0, 3) != 0);
        end
        drain();

        // Random, bursty: overflow and order errors expected along the way.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rand_step(NRET'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        @(negedge clock);
        #1;
        check("sb_drained", 512'(exp_q.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
